// File: rtl/seq_pkg.sv
// Shared types and helpers for index_sequencer.
// The DONE state is only present when SEQ_CONTINUOUS_EN is undefined.
package seq_pkg;

`ifdef SEQ_CONTINUOUS_EN
  typedef enum logic [1:0] {
    IDLE,
    RUN
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
`endif

  // The dwell counter needs $clog2(dwell) bits, but never fewer than 1.
  function automatic int unsigned dwell_width(input int unsigned dwell);
    int unsigned w;
    w = $clog2(dwell);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts accepted cycles spent on one index.
// o_tc is high while the count sits at DWELL-1, and an enabled terminal count wraps to 0.
module dwell_counter #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned W     = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [W-1:0] LAST = W'(DWELL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tc = (cnt_q == LAST);

endmodule

// File: rtl/index_sequencer.sv
// Steps o_nkb through 0..BITS-1, holding each index for DWELL accepted cycles.
// Define SEQ_CONTINUOUS_EN to wrap the index and run until stopped instead of making a single pass.
module index_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned BITS  = 9,
  parameter int unsigned DWELL = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_ready,
  output logic [BITS-1:0] o_nkb,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_done
);

  localparam int unsigned   CW       = dwell_width(DWELL);
  localparam logic [BITS-1:0] LAST_IDX = BITS'(BITS - 1);

  state_t          state_q, state_d;
  logic [BITS-1:0] nkb_q, nkb_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dwell_en, dwell_clr, dwell_tc;

  // The count only advances on accepted RUN cycles and is held at 0 elsewhere.
  assign dwell_en  = (state_q == RUN) && i_ready && !i_stop;
  assign dwell_clr = (state_q != RUN) || i_stop;

  dwell_counter #(
    .DWELL (DWELL),
    .W     (CW)
  ) u_dwell (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (dwell_en),
    .i_clr (dwell_clr),
    .o_tc  (dwell_tc)
  );

  always_comb begin
    state_d = state_q;
    nkb_d   = nkb_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        nkb_d = '0;
        if (i_start && !i_stop) state_d = RUN;
      end
      RUN: begin
        if (i_stop) begin
          state_d = IDLE;
          nkb_d   = '0;
        end else if (i_ready && dwell_tc) begin
          if (nkb_q < LAST_IDX) begin
            nkb_d = nkb_q + BITS'(1);
          end else begin
            nkb_d = '0;
`ifdef SEQ_CONTINUOUS_EN
            done_d = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifndef SEQ_CONTINUOUS_EN
      DONE: begin
        state_d = IDLE;
        nkb_d   = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        nkb_d   = '0;
      end
    endcase
    // Outputs are derived from the next state so that they leave the flops aligned with it.
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
`ifndef SEQ_CONTINUOUS_EN
    done_d  = (state_d == DONE);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      nkb_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nkb_q   <= nkb_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_nkb   = nkb_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: doc/index_sequencer.md
INDEX_SEQUENCER -- requirements
Module: index_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 9: index output width and number of positions, which are 0..BITS-1.
REQ-002 SHALL have parameter DWELL, default 4: cycles each index is held under continuous acceptance; legal range is DWELL >= 1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1 bit: begin a sequence; sampled only in IDLE.
REQ-006 SHALL have port i_stop, input, 1 bit: abort the sequence.
REQ-007 SHALL have port i_ready, input, 1 bit: downstream accepts the current index this cycle.
REQ-008 SHALL have port o_nkb, output, BITS bits: current index; drives the downstream binary-to-one-hot decoder's i_nkb.
REQ-009 SHALL have port o_valid, output, 1 bit: o_nkb is meaningful.
REQ-010 SHALL have port o_busy, output, 1 bit: the sequence is running.
REQ-011 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-013 IDLE behaviour: o_nkb=0, o_valid=0, o_busy=0, o_done=0; i_start=1 and i_stop=0 at an edge -> RUN next cycle with o_nkb=0 and dwell count 0.
REQ-014 RUN outputs: o_valid=1, o_busy=1.
REQ-015 Stall rule: i_ready=0 in RUN holds both o_nkb and the dwell count.
REQ-016 Dwell rule: i_ready=1 with dwell count < DWELL-1 increments the dwell count.
REQ-017 Advance rule: i_ready=1 with dwell count = DWELL-1 clears the dwell count and sets o_nkb+1 if o_nkb < BITS-1; otherwise the FSM goes to DONE.
REQ-018 o_nkb SHALL never exceed BITS-1, so no overflow is ever presented downstream.
REQ-019 DONE lasts exactly one cycle: o_done=1, o_valid=0, o_busy=0, o_nkb=0; then IDLE; i_start in DONE is ignored.
REQ-020 i_stop=1 in RUN -> IDLE next cycle with o_nkb=0 and no o_done, even when coinciding with the final advance.
REQ-021 i_start in RUN is ignored; i_start together with i_stop in IDLE -> remain in IDLE.
REQ-022 Zero-latency acceptance: with i_ready held 1, one pass takes exactly BITS*DWELL RUN cycles.
REQ-023 Dwell counter width SHALL be $clog2(DWELL) bits, with a minimum of 1 bit.

Reset
REQ-024 i_rst=1 SHALL immediately, without waiting for a clock edge, force IDLE, o_nkb=0, o_valid=0, o_busy=0, o_done=0 and dwell count 0, including mid-RUN.
REQ-025 After i_rst deasserts, the block SHALL be in IDLE and accept i_start at the first clock edge.

Configuration
REQ-026 Macro SEQ_CONTINUOUS_EN SHALL select continuous operation.
REQ-027 With SEQ_CONTINUOUS_EN defined, the final advance from BITS-1 SHALL wrap o_nkb to 0, stay in RUN and pulse o_done for one cycle while o_valid stays 1; only i_stop or i_rst exit.
REQ-028 Without SEQ_CONTINUOUS_EN, operation is single-pass per REQ-017 and REQ-019, and the DONE state exists only in this build.

Structure
REQ-029 Package seq_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and a function computing the dwell counter width.
REQ-030 The dwell counter SHALL be sub-module dwell_counter, with enable, clear and terminal-count output; the FSM and index register stay in index_sequencer.

Verification (BITS=4, DWELL=2)
REQ-031 Basic pass: i_start pulse, i_ready=1 -> o_nkb 0,0,1,1,2,2,3,3 with o_valid=1 for 8 cycles, then o_done=1 for 1 cycle, then IDLE.
REQ-032 Stall: i_ready=0 for 3 cycles while o_nkb=2 -> o_nkb holds 2, pass lasts 11 RUN cycles, single o_done.
REQ-033 Abort: i_stop=1 while o_nkb=1 -> next cycle o_valid=0, o_nkb=0, no o_done; i_stop on the final advance also gives no o_done.
REQ-034 Start and stop together in IDLE -> o_busy stays 0; i_start during RUN -> sequence unchanged.
REQ-035 Async reset: i_rst asserted mid-cycle at o_nkb=2 -> all outputs 0 before the next edge; a fresh i_start afterwards gives a normal pass.
REQ-036 SEQ_CONTINUOUS_EN build: o_nkb goes 3 -> 0 with o_valid=1 throughout and o_done pulses every 8 cycles until i_stop.
